// File: rtl/text_fetch_if.sv
// rtl/text_fetch_if.sv - host write / screen-clear bus between the host and text_fetch
interface text_fetch_if #(
  parameter int ADDR_W = 12
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ready;
  logic              clear_req;
  logic [7:0]        clear_attr;
  logic              busy;

  modport master (
    output wr_en, wr_addr, wr_data, clear_req, clear_attr,
    input  wr_ready, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clear_req, clear_attr,
    output wr_ready, busy
  );
endinterface

// File: rtl/text_fetch.sv
// rtl/text_fetch.sv - character-cell fetch stage: coords -> text RAM -> codepoint/attr, latency 3
// Optional hardware cursor (attribute nibble swap) enabled by defining CURSOR_EN.
module text_fetch #(
  parameter int BIT_WIDTH   = 12,
  parameter int BIT_HEIGHT  = 11,
  parameter int FONT_WIDTH  = 8,
  parameter int FONT_HEIGHT = 16,
  parameter int COLUMNS     = 80,
  parameter int ROWS        = 30,
  parameter int ADDR_W      = 12
) (
  input  logic                    clk_pixel,
  input  logic                    rst_n,
  input  logic [BIT_WIDTH-1:0]    cx_in,
  input  logic [BIT_HEIGHT-1:0]   cy_in,
  output logic [BIT_WIDTH-1:0]    cx,
  output logic [BIT_HEIGHT-1:0]   cy,
  output logic [7:0]              codepoint,
  output logic [7:0]              charattr,
  input  logic [$clog2(ROWS)-1:0] scroll_row,
`ifdef CURSOR_EN
  input  logic [6:0]              cursor_col,
  input  logic [4:0]              cursor_row,
  input  logic                    cursor_on,
`endif
  text_fetch_if.slave             host
);
  localparam int CELLS  = COLUMNS * ROWS;
  localparam int COL_SH = $clog2(FONT_WIDTH);
  localparam int ROW_SH = $clog2(FONT_HEIGHT);
  localparam int COL_W  = BIT_WIDTH - COL_SH;
  localparam int ROW_W  = BIT_HEIGHT - ROW_SH;
  localparam int SCR_W  = $clog2(ROWS);
  localparam logic [ADDR_W-1:0]     L_ROWS  = ADDR_W'(ROWS);
  localparam logic [ADDR_W-1:0]     L_COLS  = ADDR_W'(COLUMNS);
  localparam logic [ADDR_W-1:0]     L_CELLS = ADDR_W'(CELLS);
  localparam logic [ADDR_W-1:0]     L_LAST  = ADDR_W'(CELLS - 1);
  localparam logic [BIT_WIDTH-1:0]  L_XMAX  = BIT_WIDTH'(COLUMNS * FONT_WIDTH);
  localparam logic [BIT_HEIGHT-1:0] L_YMAX  = BIT_HEIGHT'(ROWS * FONT_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [7:0]        r_fill;
  logic              r_busy;
  logic              r_ready;

  logic [BIT_WIDTH-1:0]  r1_cx;
  logic [BIT_HEIGHT-1:0] r1_cy;
  logic [COL_W-1:0]      r1_col;
  logic [ROW_W-1:0]      r1_row;
  logic                  r1_vis;
  logic [SCR_W-1:0]      r_scroll;

  logic [BIT_WIDTH-1:0]  r2_cx;
  logic [BIT_HEIGHT-1:0] r2_cy;
  logic                  r2_vis;
  logic [15:0]           r_rdata;
`ifdef CURSOR_EN
  logic                  r2_cur;
`endif

  logic [15:0] r_ram [CELLS];

  logic [ADDR_W-1:0] w_row_sum;
  logic [ADDR_W-1:0] w_eff_row;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [15:0]       w_wdata;

  // Row wrap is a single conditional subtract: row < ROWS and scroll < ROWS for visible pixels.
  always_comb begin
    w_row_sum = ADDR_W'(r1_row) + ADDR_W'(r_scroll);
    w_eff_row = (w_row_sum >= L_ROWS) ? (w_row_sum - L_ROWS) : w_row_sum;
    w_raddr   = r1_vis ? (w_eff_row * L_COLS + ADDR_W'(r1_col)) : '0;
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = host.wr_addr;
    w_wdata = host.wr_data;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_cnt;
      w_wdata = {r_fill, 8'h20};
    end else if (host.wr_en && r_ready && (host.wr_addr < L_CELLS)) begin
      w_we = 1'b1;
    end
  end

  // Text RAM is deliberately outside reset so an aborted clear leaves partial content.
  always_ff @(posedge clk_pixel) begin
    if (w_we) r_ram[w_waddr] <= w_wdata;
    r_rdata <= r_ram[w_raddr];
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r1_cx     <= '0;
      r1_cy     <= '0;
      r1_col    <= '0;
      r1_row    <= '0;
      r1_vis    <= 1'b0;
      r_scroll  <= '0;
      r2_cx     <= '0;
      r2_cy     <= '0;
      r2_vis    <= 1'b0;
`ifdef CURSOR_EN
      r2_cur    <= 1'b0;
`endif
      cx        <= '0;
      cy        <= '0;
      codepoint <= '0;
      charattr  <= '0;
    end else begin
      r1_cx  <= cx_in;
      r1_cy  <= cy_in;
      r1_col <= COL_W'(cx_in >> COL_SH);
      r1_row <= ROW_W'(cy_in >> ROW_SH);
      r1_vis <= (cx_in < L_XMAX) && (cy_in < L_YMAX);
      if (cx_in == '0 && cy_in == '0)
        r_scroll <= (ADDR_W'(scroll_row) >= L_ROWS) ? '0 : scroll_row;

      r2_cx  <= r1_cx;
      r2_cy  <= r1_cy;
      r2_vis <= r1_vis;
`ifdef CURSOR_EN
      r2_cur <= cursor_on && (r1_col == COL_W'(cursor_col)) && (r1_row == ROW_W'(cursor_row));
`endif

      cx        <= r2_cx;
      cy        <= r2_cy;
      codepoint <= r2_vis ? r_rdata[7:0] : 8'h00;
`ifdef CURSOR_EN
      charattr  <= !r2_vis ? 8'h00 : (r2_cur ? {r_rdata[11:8], r_rdata[15:12]} : r_rdata[15:8]);
`else
      charattr  <= r2_vis ? r_rdata[15:8] : 8'h00;
`endif
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fill  <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (host.clear_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_fill  <= host.clear_attr;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == L_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host.busy     = r_busy;
  assign host.wr_ready = r_ready;
endmodule

// File: tb/tb_text_fetch.sv
// tb/tb_text_fetch.sv - self-checking bench for text_fetch: vector table, corner sequences, random vs model
module tb_text_fetch;
  localparam int CELLS = 2400;

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] cx_in = '0;
  logic [10:0] cy_in = '0;
  logic [11:0] cx;
  logic [10:0] cy;
  logic [7:0]  codepoint;
  logic [7:0]  charattr;
  logic [4:0]  scroll_row = '0;
`ifdef CURSOR_EN
  logic [6:0]  cursor_col = '0;
  logic [4:0]  cursor_row = '0;
  logic        cursor_on = 1'b0;
`endif

  text_fetch_if #(.ADDR_W(12)) bus ();

  text_fetch dut (
    .clk_pixel  (clk_pixel),
    .rst_n      (rst_n),
    .cx_in      (cx_in),
    .cy_in      (cy_in),
    .cx         (cx),
    .cy         (cy),
    .codepoint  (codepoint),
    .charattr   (charattr),
    .scroll_row (scroll_row),
`ifdef CURSOR_EN
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .cursor_on  (cursor_on),
`endif
    .host       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int         cx;
    int         cy;
    logic [7:0] code;
    logic [7:0] attr;
    bit         known;
  } exp_t;

  typedef struct {
    bit          we;
    int          addr;
    logic [15:0] data;
    int          scr;
    int          px;
    int          py;
    logic [7:0]  code;
    logic [7:0]  attr;
  } vec_t;

  // Reference model: a plain text screen, a latched scroll and a clear-progress count.
  logic [15:0] mem   [CELLS];
  bit          known [CELLS];
  int          m_scroll;
  int          clear_left;
  int          clr_idx;
  bit          in_done;
  logic [7:0]  fill;
  exp_t        q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z.cx = 0; z.cy = 0; z.code = 8'h00; z.attr = 8'h00; z.known = 1'b1;
    clear_left = 0;
    in_done    = 1'b0;
    m_scroll   = 0;
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic model_edge(input int px, input int py, input int scr, input bit we,
                            input int addr, input logic [15:0] data, input bit creq,
                            input logic [7:0] cattr);
    bit   was_clear;
    bit   was_done;
    exp_t e;
    int   a;
    was_clear = clear_left > 0;
    was_done  = in_done;
    in_done   = 1'b0;
    if (was_clear) begin
      mem[clr_idx]   = {fill, 8'h20};
      known[clr_idx] = 1'b1;
      clr_idx++;
      clear_left--;
      if (clear_left == 0) in_done = 1'b1;
    end else begin
      if (we && addr < CELLS) begin
        mem[addr]   = data;
        known[addr] = 1'b1;
      end
      if (!was_done && creq) begin
        clear_left = CELLS;
        clr_idx    = 0;
        fill       = cattr;
      end
    end
    if (px == 0 && py == 0) m_scroll = (scr >= 30) ? 0 : scr;
    e.cx = px;
    e.cy = py;
    if (px < 640 && py < 480) begin
      a       = ((py / 16 + m_scroll) % 30) * 80 + px / 8;
      e.known = known[a];
      e.code  = mem[a][7:0];
      e.attr  = mem[a][15:8];
    end else begin
      e.known = 1'b1;
      e.code  = 8'h00;
      e.attr  = 8'h00;
    end
    q.push_back(e);
  endtask

  task automatic cyc(input int px, input int py, input int scr, input bit we, input int addr,
                     input logic [15:0] data, input bit creq, input logic [7:0] cattr);
    exp_t e;
    cx_in          = 12'(px);
    cy_in          = 11'(py);
    scroll_row     = 5'(scr);
    bus.wr_en      = we;
    bus.wr_addr    = 12'(addr);
    bus.wr_data    = data;
    bus.clear_req  = creq;
    bus.clear_attr = cattr;
    @(posedge clk_pixel);
    model_edge(px, py, scr, we, addr, data, creq, cattr);
    #1;
    e = q.pop_front();
    chk("pipe_cx", 32'(cx), 32'(e.cx));
    chk("pipe_cy", 32'(cy), 32'(e.cy));
    if (e.known) begin
      chk("pipe_codepoint", 32'(codepoint), 32'(e.code));
      chk("pipe_charattr", 32'(charattr), 32'(e.attr));
    end
    chk("busy", 32'(bus.busy), 32'(clear_left > 0));
    chk("wr_ready", 32'(bus.wr_ready), 32'(clear_left == 0));
    bus.wr_en     = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(700, 0, 0, 1'b0, 0, 16'h0, 1'b0, 8'h00);
  endtask

  task automatic probe(input string name, input int px, input int py, input int scr,
                       input logic [7:0] code, input logic [7:0] attr);
    cyc(px, py, scr, 1'b0, 0, 16'h0, 1'b0, 8'h00);
    cyc(700, 0, scr, 1'b0, 0, 16'h0, 1'b0, 8'h00);
    cyc(700, 0, scr, 1'b0, 0, 16'h0, 1'b0, 8'h00);
    chk({name, "_code"}, 32'(codepoint), 32'(code));
    chk({name, "_attr"}, 32'(charattr), 32'(attr));
    chk({name, "_cx"}, 32'(cx), 32'(px));
  endtask

  task automatic rst_apply();
    bus.wr_en     = 1'b0;
    bus.clear_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_codepoint", 32'(codepoint), 32'd0);
    chk("rst_charattr", 32'(charattr), 32'd0);
    chk("rst_cx", 32'(cx), 32'd0);
    chk("rst_cy", 32'(cy), 32'd0);
    repeat (2) @(posedge clk_pixel);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not reach the end (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   busy_cnt;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clear_req = 1'b0; bus.clear_attr = '0;
    #2;
    rst_apply();

    // Screen clear with writes and extra clear requests during CLEAR and DONE.
    cyc(0, 0, 0, 1'b0, 0, 16'h0, 1'b1, 8'h17);
    busy_cnt = bus.busy ? 1 : 0;
    for (int k = 0; k < 2406; k++) begin
      cyc((k % 80) * 8, ((k / 80) % 30) * 16, 0, k == 1000, 5, 16'hBEEF,
          (k == 500) || (k == 2400), 8'h99);
      if (bus.busy) busy_cnt++;
    end
    chk("clear_busy_cycles", 32'(busy_cnt), 32'd2400);
    for (int c = 0; c < CELLS; c++) cyc((c % 80) * 8, (c / 80) * 16, 0, 1'b0, 0, 16'h0, 1'b0, 8'h00);
    probe("clear_cell5", 40, 0, 0, 8'h20, 8'h17);
    probe("clear_cell2399", 632, 464, 0, 8'h20, 8'h17);

    tbl.push_back('{1'b1, 0,    16'h0741, 0,  0,   0,   8'h41, 8'h07});
    tbl.push_back('{1'b0, 0,    16'h0000, 0,  7,   0,   8'h41, 8'h07});
    tbl.push_back('{1'b1, 81,   16'h1F42, 0,  8,   16,  8'h42, 8'h1F});
    tbl.push_back('{1'b0, 0,    16'h0000, 0,  16,  16,  8'h20, 8'h17});
    tbl.push_back('{1'b1, 82,   16'h2B55, 0,  16,  16,  8'h55, 8'h2B});
    tbl.push_back('{1'b0, 0,    16'h0000, 0,  640, 0,   8'h00, 8'h00});
    tbl.push_back('{1'b0, 0,    16'h0000, 0,  0,   480, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 0,    16'h0000, 0,  639, 479, 8'h20, 8'h17});
    tbl.push_back('{1'b1, 2320, 16'h0733, 29, 0,   0,   8'h33, 8'h07});
    tbl.push_back('{1'b0, 0,    16'h0000, 29, 8,   32,  8'h42, 8'h1F});
    tbl.push_back('{1'b1, 2400, 16'hFFFF, 0,  0,   0,   8'h41, 8'h07});
    tbl.push_back('{1'b0, 0,    16'h0000, 31, 8,   16,  8'h42, 8'h1F});
    tbl.push_back('{1'b0, 0,    16'h0000, 30, 0,   0,   8'h41, 8'h07});
    tbl.push_back('{1'b1, 2399, 16'h6677, 1,  632, 464, 8'h20, 8'h17});
    tbl.push_back('{1'b0, 0,    16'h0000, 1,  632, 448, 8'h77, 8'h66});
    foreach (tbl[i]) begin
      if (tbl[i].we) cyc(700, 0, 0, 1'b1, tbl[i].addr, tbl[i].data, 1'b0, 8'h00);
      cyc(0, 0, tbl[i].scr, 1'b0, 0, 16'h0, 1'b0, 8'h00);
      probe($sformatf("vec%0d", i), tbl[i].px, tbl[i].py, tbl[i].scr, tbl[i].code, tbl[i].attr);
    end

    // scroll_row changes away from (0,0) must not take effect until the next frame start.
    cyc(0, 0, 29, 1'b0, 0, 16'h0, 1'b0, 8'h00);
    probe("midframe_hold", 0, 16, 0, 8'h41, 8'h07);
    probe("frame_relatch", 0, 0, 0, 8'h41, 8'h07);
    probe("midframe_new", 0, 16, 0, 8'h20, 8'h17);

    // Write one cell then read it back immediately, including same-cycle collisions.
    cyc(700, 0, 0, 1'b1, 1, 16'hA1B2, 1'b0, 8'h00);
    cyc(8, 0, 0, 1'b1, 1, 16'hC3D4, 1'b0, 8'h00);
    cyc(8, 0, 0, 1'b0, 0, 16'h0, 1'b0, 8'h00);
    idle(2);

    for (int n = 0; n < 800; n++) begin
      int r;
      int px;
      int py;
      r = $urandom_range(0, 99);
      if (r >= 95) begin
        px = 0; py = 0;
      end else begin
        px = $urandom_range(0, 700);
        py = $urandom_range(0, 520);
      end
      cyc(px, py, $urandom_range(0, 31), r < 30, $urandom_range(0, 2599), 16'($urandom),
          1'b0, 8'h00);
    end

    // Reset partway through a clear: cells already written keep the fill, the rest stay.
    cyc(700, 0, 0, 1'b1, 99,  16'h4321, 1'b0, 8'h00);
    cyc(700, 0, 0, 1'b1, 100, 16'h1234, 1'b0, 8'h00);
    cyc(700, 0, 0, 1'b0, 0, 16'h0, 1'b1, 8'h3C);
    idle(100);
    rst_apply();
    probe("abort_cell99", 152, 16, 0, 8'h20, 8'h3C);
    probe("abort_cell100", 160, 16, 0, 8'h34, 8'h12);
    probe("abort_cell0", 0, 0, 0, 8'h20, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
